vector_sequencer: RTL and testbench

Multi-cycle controller that executes the vector instructions ADDV and MULV by stepping the single shared lane ALU/multiplier through every lane of the vector register file, one lane at a time. It sits beside the control unit's decoder. It accepts a start pulse when a vector instruction issues, stalls fetch/decode while it runs, and drives vector register file read/write addresses, the lane index, and ALU control until the last lane is written.

---
 rtl/vector_sequencer.sv | 174 +++++++++++++++++
 tb/tb_vector_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// vector_sequencer
//   Steps the single shared lane ALU/multiplier through every lane of the
//   vector register file to execute ADDV / MULV, one lane at a time.
//   Each lane goes through READ (operand capture), EXEC (1 cycle for ADDV,
//   MUL_LAT cycles for MULV) and WRITE (lane write-back).
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   Start, VOp           issue pulse and operation (00 ADDV, 01 MULV, else illegal)
//   VRd, VRn, VRm        destination / source vector register indices
//   Flush                abandon the current instruction
//   Busy, Stall          sequencer active / hold fetch-decode
//   Done, Error          completion pulse / illegal-op pulse
//   LaneIdx              current lane
//   VRA1, VRA2, VWA      latched VRn, VRm, VRd
//   OpLatch, LaneWE      capture lane operands / write lane result
//   ALUControlV          0000 ADD, 0101 MUL, held for the whole instruction
module vector_sequencer #(
   parameter int LANES   = 4,
   parameter int MUL_LAT = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Start,
   input  logic [1:0]                 VOp,
   input  logic [2:0]                 VRd,
   input  logic [2:0]                 VRn,
   input  logic [2:0]                 VRm,
   input  logic                       Flush,
   output logic                       Busy,
   output logic                       Stall,
   output logic                       Done,
   output logic                       Error,
   output logic [$clog2(LANES)-1:0]   LaneIdx,
   output logic [2:0]                 VRA1,
   output logic [2:0]                 VRA2,
   output logic [2:0]                 VWA,
   output logic                       OpLatch,
   output logic                       LaneWE,
   output logic [3:0]                 ALUControlV
);

   localparam int LW = $clog2(LANES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [LW-1:0]  lane_q,  lane_d;
   logic [3:0]     cnt_q,   cnt_d;
   logic [2:0]     vra1_q,  vra1_d;
   logic [2:0]     vra2_q,  vra2_d;
   logic [2:0]     vwa_q,   vwa_d;
   logic [3:0]     alu_q,   alu_d;
   logic           mul_q,   mul_d;
   logic           error_q, error_d;

   logic           legal_op;
   logic           op_latch;
   logic           lane_we;
   logic           done;

   // Only 00 and 01 are defined, so the high opcode bit alone marks illegal.
   assign legal_op = ~VOp[1];

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      cnt_d    = cnt_q;
      vra1_d   = vra1_q;
      vra2_d   = vra2_q;
      vwa_d    = vwa_q;
      alu_d    = alu_q;
      mul_d    = mul_q;
      error_d  = 1'b0;
      op_latch = 1'b0;
      lane_we  = 1'b0;
      done     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Flush in the same cycle suppresses both acceptance and Error.
            if (Start && !Flush) begin
               if (legal_op) begin
                  vra1_d  = VRn;
                  vra2_d  = VRm;
                  vwa_d   = VRd;
                  mul_d   = VOp[0];
                  alu_d   = VOp[0] ? 4'b0101 : 4'b0000;
                  lane_d  = '0;
                  state_d = S_READ;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_READ: begin
            op_latch = 1'b1;
            cnt_d    = mul_q ? 4'(MUL_LAT - 1) : 4'd0;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            if (cnt_q == 4'd0) state_d = S_WRITE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_WRITE: begin
            lane_we = 1'b1;
            if (lane_q == LW'(LANES - 1)) begin
               state_d = S_DONE;
            end else begin
               lane_d  = lane_q + LW'(1);
               state_d = S_READ;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            lane_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abandon: lanes already written stay written, the current one is not.
      if (Flush && state_q != S_IDLE) begin
         state_d = S_IDLE;
         lane_d  = '0;
         lane_we = 1'b0;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         cnt_q   <= '0;
         vra1_q  <= '0;
         vra2_q  <= '0;
         vwa_q   <= '0;
         alu_q   <= '0;
         mul_q   <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         vra1_q  <= vra1_d;
         vra2_q  <= vra2_d;
         vwa_q   <= vwa_d;
         alu_q   <= alu_d;
         mul_q   <= mul_d;
         error_q <= error_d;
      end
   end

   assign Busy        = (state_q != S_IDLE);
   // Issue-cycle stall must be combinational so decode holds before the FSM moves.
   assign Stall       = Busy | (Start & legal_op & ~Flush);
   assign Done        = done;
   assign Error       = error_q;
   assign LaneIdx     = lane_q;
   assign VRA1        = vra1_q;
   assign VRA2        = vra2_q;
   assign VWA         = vwa_q;
   assign OpLatch     = op_latch;
   assign LaneWE      = lane_we;
   assign ALUControlV = alu_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer (LANES=4, MUL_LAT=3).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge, so each drive() call is one clock cycle of the timeline.
module tb_vector_sequencer;

   localparam int LANES   = 4;
   localparam int MUL_LAT = 3;

   logic        clk = 1'b0;
   logic        reset, Start, Flush;
   logic [1:0]  VOp;
   logic [2:0]  VRd, VRn, VRm;
   logic        Busy, Stall, Done, Error, OpLatch, LaneWE;
   logic [1:0]  LaneIdx;
   logic [2:0]  VRA1, VRA2, VWA;
   logic [3:0]  ALUControlV;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vector_sequencer #(.LANES(LANES), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .Start(Start), .VOp(VOp),
      .VRd(VRd), .VRn(VRn), .VRm(VRm), .Flush(Flush),
      .Busy(Busy), .Stall(Stall), .Done(Done), .Error(Error),
      .LaneIdx(LaneIdx), .VRA1(VRA1), .VRA2(VRA2), .VWA(VWA),
      .OpLatch(OpLatch), .LaneWE(LaneWE), .ALUControlV(ALUControlV)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic st, input logic [1:0] op,
                        input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                        input logic fl);
      @(posedge clk);
      #1;
      reset = rst; Start = st; VOp = op; VRd = rd; VRn = rn; VRm = rm; Flush = fl;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_lane"}, 32'(LaneIdx), 0);
      chk({tag, "_vra1"}, 32'(VRA1), 0);
      chk({tag, "_vra2"}, 32'(VRA2), 0);
      chk({tag, "_vwa"},  32'(VWA), 0);
      chk({tag, "_alu"},  32'(ALUControlV), 0);
      chk({tag, "_busy"}, 32'(Busy), 0);
      chk({tag, "_stall"}, 32'(Stall), 0);
      chk({tag, "_done"}, 32'(Done), 0);
      chk({tag, "_err"},  32'(Error), 0);
      chk({tag, "_we"},   32'(LaneWE), 0);
      chk({tag, "_opl"},  32'(OpLatch), 0);
   endtask

   // Issue one instruction at cycle 0 and check every cycle up to DONE
   // against the published timeline: READ at P*k+1, write at P*(k+1),
   // Done at 4P+1. abort_at >= 1 ends the run in that cycle with either
   // Flush (abort_rst=0) or reset (abort_rst=1).
   task automatic run_instr(input string nm, input logic [1:0] op,
                            input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                            input int p, input logic [3:0] alu_exp,
                            input int abort_at, input logic abort_rst);
      int last;
      last = p * LANES + 1;
      drive(1'b0, 1'b1, op, rd, rn, rm, 1'b0);
      chk($sformatf("%s_c0_stall", nm), 32'(Stall), 1);
      chk($sformatf("%s_c0_busy", nm),  32'(Busy), 0);
      chk($sformatf("%s_c0_we", nm),    32'(LaneWE), 0);
      for (int c = 1; c <= last; c++) begin
         if (c == abort_at) begin
            drive(abort_rst, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, ~abort_rst);
            chk($sformatf("%s_abort_we@%0d", nm, c),   32'(LaneWE), 0);
            chk($sformatf("%s_abort_done@%0d", nm, c), 32'(Done), 0);
            chk($sformatf("%s_abort_busy@%0d", nm, c), 32'(Busy), 1);
            return;
         end
         idle();
         chk($sformatf("%s_we@%0d", nm, c),    32'(LaneWE), 32'((c % p) == 0));
         chk($sformatf("%s_opl@%0d", nm, c),   32'(OpLatch), 32'((c % p) == 1 && c < last));
         chk($sformatf("%s_lane@%0d", nm, c),  32'(LaneIdx),
             (c == last) ? 32'(LANES - 1) : 32'((c - 1) / p));
         chk($sformatf("%s_done@%0d", nm, c),  32'(Done), 32'(c == last));
         chk($sformatf("%s_busy@%0d", nm, c),  32'(Busy), 1);
         chk($sformatf("%s_stall@%0d", nm, c), 32'(Stall), 1);
         chk($sformatf("%s_vra1@%0d", nm, c),  32'(VRA1), 32'(rn));
         chk($sformatf("%s_vra2@%0d", nm, c),  32'(VRA2), 32'(rm));
         chk($sformatf("%s_vwa@%0d", nm, c),   32'(VWA), 32'(rd));
         chk($sformatf("%s_alu@%0d", nm, c),   32'(ALUControlV), 32'(alu_exp));
      end
   endtask

   initial begin
      reset = 1'b1; Start = 1'b0; Flush = 1'b0; VOp = 2'b00;
      VRd = 3'd0; VRn = 3'd0; VRm = 3'd0;

      // Reset state
      drive(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
      chk_all_zero("rst");
      idle();
      chk("rst_rel_busy", 32'(Busy), 0);

      // ADDV: writes at 3,6,9,12, Done at 13, Busy low at 14
      run_instr("addv", 2'b00, 3'd2, 3'd0, 3'd1, 3, 4'b0000, -1, 1'b0);
      idle();
      chk("addv_t14_busy",  32'(Busy), 0);
      chk("addv_t14_stall", 32'(Stall), 0);
      chk("addv_t14_done",  32'(Done), 0);
      chk("addv_t14_we",    32'(LaneWE), 0);
      chk("addv_hold_vwa",  32'(VWA), 2);
      chk("addv_hold_vra1", 32'(VRA1), 0);
      chk("addv_hold_vra2", 32'(VRA2), 1);
      chk("addv_hold_lane", 32'(LaneIdx), 0);

      // MULV: OpLatch 1,6,11,16; writes 5,10,15,20; Done 21
      run_instr("mulv", 2'b01, 3'd5, 3'd6, 3'd7, 2 + MUL_LAT, 4'b0101, -1, 1'b0);
      idle();
      chk("mulv_t22_busy", 32'(Busy), 0);
      chk("mulv_hold_alu", 32'(ALUControlV), 4'b0101);
      chk("mulv_hold_vwa", 32'(VWA), 5);

      // Illegal op
      drive(1'b0, 1'b1, 2'b10, 3'd1, 3'd1, 3'd1, 1'b0);
      chk("ill_t0_stall", 32'(Stall), 0);
      chk("ill_t0_busy",  32'(Busy), 0);
      chk("ill_t0_err",   32'(Error), 0);
      idle();
      chk("ill_t1_err",   32'(Error), 1);
      chk("ill_t1_busy",  32'(Busy), 0);
      chk("ill_t1_stall", 32'(Stall), 0);
      chk("ill_t1_we",    32'(LaneWE), 0);
      chk("ill_t1_vwa",   32'(VWA), 5);
      idle();
      chk("ill_t2_err",   32'(Error), 0);
      chk("ill_t2_busy",  32'(Busy), 0);

      // Flush and Start in the same IDLE cycle: nothing accepted
      drive(1'b0, 1'b1, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1);
      chk("fs_stall", 32'(Stall), 0);
      idle();
      chk("fs_busy", 32'(Busy), 0);
      chk("fs_err",  32'(Error), 0);
      chk("fs_vwa",  32'(VWA), 5);

      // Flush at t7 during ADDV; new Start at t8 (cycle 0 of next run checks Busy=0)
      run_instr("flush", 2'b00, 3'd2, 3'd0, 3'd1, 3, 4'b0000, 7, 1'b0);
      run_instr("after_flush", 2'b00, 3'd4, 3'd4, 3'd4, 3, 4'b0000, -1, 1'b0);

      // Back-to-back ADDV with aliasing; second Start lands at t14
      run_instr("b2b_a", 2'b00, 3'd3, 3'd3, 3'd1, 3, 4'b0000, -1, 1'b0);
      run_instr("b2b_b", 2'b00, 3'd3, 3'd3, 3'd2, 3, 4'b0000, -1, 1'b0);
      idle();
      chk("b2b_end_busy",  32'(Busy), 0);
      chk("b2b_end_stall", 32'(Stall), 0);

      // Reset during lane-1 EXEC of MULV (cycle 7)
      run_instr("rmul", 2'b01, 3'd5, 3'd6, 3'd7, 2 + MUL_LAT, 4'b0101, 7, 1'b1);
      idle();
      chk_all_zero("rmid");
      idle();
      chk("rmid_t2_we",   32'(LaneWE), 0);
      chk("rmid_t2_busy", 32'(Busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
      $finish;
   end

endmodule
